// File: rtl/ex_mem_stage_if.sv
// rtl/ex_mem_stage_if.sv - execute-to-memory stage bus bundle
interface ex_mem_stage_if #(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [XLEN-1:0] alu_result;
  logic            zero_flag;
  logic [XLEN-1:0] store_data;
  logic [4:0]      rd_addr;
  logic            reg_write;
  logic            mem_read;
  logic            mem_write;
  logic            branch_en;
  logic            branch_ne;
  logic [XLEN-1:0] branch_target_in;
  logic            flush;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_alu_result;
  logic [XLEN-1:0] out_store_data;
  logic [4:0]      out_rd;
  logic            out_reg_write;
  logic            out_mem_read;
  logic            out_mem_write;
  logic            branch_taken;
  logic [XLEN-1:0] branch_target;

  // Environment side: offers execute entries, consumes memory-stage entries
  modport master (
    output in_valid, alu_result, zero_flag, store_data, rd_addr,
           reg_write, mem_read, mem_write, branch_en, branch_ne,
           branch_target_in, flush, out_ready,
    input  in_ready, out_valid, out_alu_result, out_store_data, out_rd,
           out_reg_write, out_mem_read, out_mem_write, branch_taken, branch_target
  );

  // Stage side
  modport slave (
    input  in_valid, alu_result, zero_flag, store_data, rd_addr,
           reg_write, mem_read, mem_write, branch_en, branch_ne,
           branch_target_in, flush, out_ready,
    output in_ready, out_valid, out_alu_result, out_store_data, out_rd,
           out_reg_write, out_mem_read, out_mem_write, branch_taken, branch_target
  );
endinterface

// File: rtl/ex_mem_stage.sv
// rtl/ex_mem_stage.sv - two-entry EX/MEM skid buffer with branch redirect pulse
module ex_mem_stage #(
  parameter int XLEN = 32
) (
  input logic          clk,
  input logic          reset,
  ex_mem_stage_if.slave bus
);
  typedef struct packed {
    logic [XLEN-1:0] alu_result;
    logic [XLEN-1:0] store_data;
    logic [4:0]      rd;
    logic            reg_write;
    logic            mem_read;
    logic            mem_write;
  } entry_t;

  entry_t          head_q;
  entry_t          skid_q;
  entry_t          in_entry;
  logic [1:0]      occ_q;
  logic [1:0]      occ_next;
  logic            in_ready_q;
  logic            branch_taken_q;
  logic [XLEN-1:0] branch_target_q;
  logic            push;
  logic            pop;
  logic            taken;

  // Handshake decode and next occupancy; in_ready_q is low at occ=2 so push never occurs there
  always_comb begin
    push     = bus.in_valid && in_ready_q && !bus.flush;
    pop      = (occ_q != 2'd0) && bus.out_ready;
    taken    = bus.branch_en && (bus.branch_ne ? !bus.zero_flag : bus.zero_flag);
    in_entry = '{alu_result: bus.alu_result, store_data: bus.store_data,
                 rd: bus.rd_addr, reg_write: bus.reg_write,
                 mem_read: bus.mem_read, mem_write: bus.mem_write};
    occ_next = occ_q;
    case (occ_q)
      2'd0:    if (push) occ_next = 2'd1;
      2'd1:    if (push && !pop) occ_next = 2'd2;
               else if (pop && !push) occ_next = 2'd0;
      2'd2:    if (pop) occ_next = 2'd1;
      default: occ_next = 2'd0;
    endcase
  end

  // Buffer state, registered ready and branch redirect; reset beats flush beats handshakes
  always_ff @(posedge clk) begin
    if (reset) begin
      head_q          <= '0;
      skid_q          <= '0;
      occ_q           <= 2'd0;
      in_ready_q      <= 1'b1;
      branch_taken_q  <= 1'b0;
      branch_target_q <= '0;
    end else if (bus.flush) begin
      occ_q          <= 2'd0;
      in_ready_q     <= 1'b1;
      branch_taken_q <= 1'b0;
    end else begin
      occ_q          <= occ_next;
      in_ready_q     <= (occ_next != 2'd2);
      branch_taken_q <= push && taken;
      if (push && taken) branch_target_q <= bus.branch_target_in;
      case (occ_q)
        2'd0: if (push) head_q <= in_entry;
        2'd1: begin
          if (push && pop) head_q <= in_entry;
          else if (push)   skid_q <= in_entry;
        end
        2'd2: if (pop) head_q <= skid_q;
        default: ;
      endcase
    end
  end

  assign bus.in_ready       = in_ready_q;
  assign bus.out_valid      = (occ_q != 2'd0);
  assign bus.out_alu_result = head_q.alu_result;
  assign bus.out_store_data = head_q.store_data;
  assign bus.out_rd         = head_q.rd;
  assign bus.out_reg_write  = head_q.reg_write;
  assign bus.out_mem_read   = head_q.mem_read;
  assign bus.out_mem_write  = head_q.mem_write;
  assign bus.branch_taken   = branch_taken_q;
  assign bus.branch_target  = branch_target_q;
endmodule

// File: tb/tb_ex_mem_stage.sv
// tb/tb_ex_mem_stage.sv - table-driven testbench for ex_mem_stage
module tb_ex_mem_stage;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   failures = 0;

  ex_mem_stage_if #(.XLEN(32)) bus();

  ex_mem_stage #(.XLEN(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        iv;
    logic [31:0] alu;
    logic        zf;
    logic        ben;
    logic        bne;
    logic [31:0] tgt;
    logic        fl;
    logic        ordy;
    logic        ev;
    logic        eir;
    logic [31:0] ealu;
    logic        ebt;
    logic [31:0] etgt;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic iv, input logic [31:0] alu, input logic zf,
                     input logic ben, input logic bne, input logic [31:0] tgt,
                     input logic fl, input logic ordy, input logic ev, input logic eir,
                     input logic [31:0] ealu, input logic ebt, input logic [31:0] etgt);
    vec_t v;
    v.iv = iv; v.alu = alu; v.zf = zf; v.ben = ben; v.bne = bne; v.tgt = tgt;
    v.fl = fl; v.ordy = ordy; v.ev = ev; v.eir = eir; v.ealu = ealu;
    v.ebt = ebt; v.etgt = etgt;
    vecs.push_back(v);
  endtask

  // Side fields are derived from alu_result so the whole entry can be checked
  task automatic drive(input logic iv, input logic [31:0] alu, input logic zf,
                       input logic ben, input logic bne, input logic [31:0] tgt,
                       input logic fl, input logic ordy);
    bus.in_valid         = iv;
    bus.alu_result       = alu;
    bus.store_data       = ~alu;
    bus.rd_addr          = alu[4:0];
    bus.reg_write        = alu[0];
    bus.mem_read         = alu[1];
    bus.mem_write        = alu[2];
    bus.zero_flag        = zf;
    bus.branch_en        = ben;
    bus.branch_ne        = bne;
    bus.branch_target_in = tgt;
    bus.flush            = fl;
    bus.out_ready        = ordy;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic check_state(input string tag, input logic ev, input logic eir,
                             input logic [31:0] ealu, input logic ebt, input logic [31:0] etgt);
    logic [31:0] inv;
    inv = ~ealu;
    check({tag, "_out_valid"}, {31'd0, bus.out_valid}, {31'd0, ev});
    check({tag, "_in_ready"}, {31'd0, bus.in_ready}, {31'd0, eir});
    check({tag, "_branch_taken"}, {31'd0, bus.branch_taken}, {31'd0, ebt});
    check({tag, "_branch_target"}, bus.branch_target, etgt);
    if (ev) begin
      check({tag, "_out_alu"}, bus.out_alu_result, ealu);
      check({tag, "_out_store"}, bus.out_store_data, inv);
      check({tag, "_out_rd"}, {27'd0, bus.out_rd}, {27'd0, ealu[4:0]});
      check({tag, "_out_ctrl"}, {29'd0, bus.out_mem_write, bus.out_mem_read, bus.out_reg_write},
            {29'd0, ealu[2:0]});
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  initial begin
    //   iv  alu        zf ben bne tgt        fl ordy ev eir ealu       ebt etgt
    // streaming with one-cycle latency
    add(1, 32'h1,      0, 0, 0, 32'h0,    0, 1,   1, 1,  32'h1,     0, 32'h0);
    add(1, 32'h2,      1, 0, 0, 32'h0,    0, 1,   1, 1,  32'h2,     0, 32'h0);
    add(1, 32'h3,      0, 0, 0, 32'h0,    0, 1,   1, 1,  32'h3,     0, 32'h0);
    add(1, 32'h4,      0, 0, 0, 32'h0,    0, 1,   1, 1,  32'h4,     0, 32'h0);
    add(0, 32'h0,      0, 0, 0, 32'h0,    0, 1,   0, 1,  32'h0,     0, 32'h0);
    // backpressure fills skid, third offer held off, then drains in order
    add(1, 32'h10,     0, 0, 0, 32'h0,    0, 0,   1, 1,  32'h10,    0, 32'h0);
    add(1, 32'h20,     0, 0, 0, 32'h0,    0, 0,   1, 0,  32'h10,    0, 32'h0);
    add(1, 32'h30,     0, 0, 0, 32'h0,    0, 0,   1, 0,  32'h10,    0, 32'h0);
    add(1, 32'h30,     0, 0, 0, 32'h0,    0, 1,   1, 1,  32'h20,    0, 32'h0);
    add(1, 32'h30,     0, 0, 0, 32'h0,    0, 1,   1, 1,  32'h30,    0, 32'h0);
    add(0, 32'h0,      0, 0, 0, 32'h0,    0, 1,   0, 1,  32'h0,     0, 32'h0);
    // BEQ taken while stalled: single pulse
    add(1, 32'h40,     1, 1, 0, 32'h100,  0, 0,   1, 1,  32'h40,    1, 32'h100);
    add(0, 32'h0,      0, 0, 0, 32'h0,    0, 0,   1, 1,  32'h40,    0, 32'h100);
    add(0, 32'h0,      0, 0, 0, 32'h0,    0, 0,   1, 1,  32'h40,    0, 32'h100);
    add(0, 32'h0,      0, 0, 0, 32'h0,    0, 1,   0, 1,  32'h0,     0, 32'h100);
    // BNE not taken, BNE taken, BEQ not taken into full buffer
    add(1, 32'h50,     1, 1, 1, 32'h200,  0, 1,   1, 1,  32'h50,    0, 32'h100);
    add(1, 32'h60,     0, 1, 1, 32'h300,  0, 1,   1, 1,  32'h60,    1, 32'h300);
    add(1, 32'h70,     0, 1, 0, 32'h400,  0, 0,   1, 0,  32'h60,    0, 32'h300);
    // flush at occ=2 with a taken branch offered: dropped, no pulse
    add(1, 32'h80,     1, 1, 0, 32'h500,  1, 0,   0, 1,  32'h0,     0, 32'h300);
    add(0, 32'h0,      0, 0, 0, 32'h0,    0, 1,   0, 1,  32'h0,     0, 32'h300);

    drive(1, 32'hFFFF_FFFF, 1, 1, 0, 32'hDEAD, 0, 1);
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    check("rst_branch_taken", {31'd0, bus.branch_taken}, 32'd0);
    check("rst_branch_target", bus.branch_target, 32'd0);
    check("rst_out_alu", bus.out_alu_result, 32'd0);
    check("rst_out_store", bus.out_store_data, 32'd0);
    check("rst_out_rd", {27'd0, bus.out_rd}, 32'd0);

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].iv, vecs[i].alu, vecs[i].zf, vecs[i].ben, vecs[i].bne,
            vecs[i].tgt, vecs[i].fl, vecs[i].ordy);
      step();
      check_state($sformatf("v%0d", i), vecs[i].ev, vecs[i].eir, vecs[i].ealu,
                  vecs[i].ebt, vecs[i].etgt);
    end

    // reset at occ=2 with a branch pulse showing clears everything
    drive(1, 32'hA1, 0, 0, 0, 32'h0, 0, 0);
    step();
    check_state("r1", 1, 1, 32'hA1, 0, 32'h300);
    drive(1, 32'hB2, 1, 1, 0, 32'h700, 0, 0);
    step();
    check_state("r2", 1, 0, 32'hA1, 1, 32'h700);
    reset = 1'b1;
    drive(1, 32'hC3, 1, 1, 0, 32'h900, 1, 1);
    step();
    reset = 1'b0;
    check_state("r3", 0, 1, 32'h0, 0, 32'h0);
    check("r3_out_alu_zero", bus.out_alu_result, 32'd0);
    check("r3_out_store_zero", bus.out_store_data, 32'd0);
    drive(0, 32'h0, 0, 0, 0, 32'h0, 0, 1);
    step();
    check_state("r4", 0, 1, 32'h0, 0, 32'h0);
    drive(1, 32'hD4, 0, 0, 0, 32'h0, 0, 1);
    step();
    check_state("r5", 1, 1, 32'hD4, 0, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
